sonic_reg_router: RTL and testbench
===================================

// Module: sonic_reg_router
// PURPOSE
// - N-port BAR register router between sonic_rxtx_downstream_intf and per-port register banks (dma_rd/dma_wr/irq/cmd).
// - Replaces the fixed two-copy p0/p1 register-access arrangement with one parametrised block.
// - Adds target decode, an explicit read FSM, write/read conflict arbitration, back-pressure and an error counter.
// PARAMETERS
// - NUM_PORTS  2   register-bank ports; sel_port is one bit per port
// - NUM_TGT    4   targets per port; target index = reg_*_addr[ADDR_W-1 -: TGT_W], TGT_W=$clog2(NUM_TGT)
// - ADDR_W     8   register address width
// - DATA_W     32  register data width; must be a multiple of 16
// - RD_LAT     2   bank read latency, in cycles from prg_addr to valid prg_rddata; legal range 1..15
// PORTS
// - clk_in             in   1                       clock; single clock domain
// - rstn               in   1                       asynchronous, active-low reset
// - sel_port           in   NUM_PORTS               one-hot port select from the downstream interface
// - reg_wr_ena         in   1                       write strobe
// - reg_wr_addr        in   ADDR_W                  write address
// - reg_wr_data        in   DATA_W                  write data
// - reg_rd_ena         in   1                       read strobe
// - reg_rd_addr        in   ADDR_W                  read address
// - reg_rd_data        out  DATA_W                  read response data
// - reg_rd_data_valid  out  1                       1-cycle pulse; response valid
// - reg_busy           out  1                       high while a read is outstanding (FSM != IDLE)
// - prg_addr           out  NUM_PORTS*ADDR_W        per-port bank address
// - prg_wrdata         out  NUM_PORTS*DATA_W        per-port bank write data
// - prg_wrena          out  NUM_PORTS*NUM_TGT       per-port, per-target write enable
// - prg_rddata         in   NUM_PORTS*NUM_TGT*DATA_W  per-port, per-target bank read data
// - err_cnt            out  16                      saturating protocol-error count
// BEHAVIOUR
// - Reset: every output and internal register is 0. FSM=IDLE. Any pending read is discarded and produces no valid pulse.
// - Write with a legal sel_port (exactly one bit set), port p, target t, cycle T:
//   - at T+1: prg_addr[p]=addr, prg_wrdata[p]=data, prg_wrena[p*NUM_TGT+t]=1 for exactly 1 cycle.
//   - Writes are accepted whether or not reg_busy is high.
// - Read FSM states: IDLE, ISSUE, WAIT, RESP.
//   - IDLE: reg_rd_ena with legal sel -> latch p, t, addr; go to ISSUE.
//   - ISSUE: load prg_addr[p]=addr; load cnt=RD_LAT-1; go to WAIT.
//     - If a write to port p is accepted this same cycle, the write owns prg_addr[p]; stay in ISSUE one cycle.
//   - WAIT: decrement cnt; at cnt==0 go to RESP.
//   - RESP: reg_rd_data=prg_rddata[p][t]; reg_rd_data_valid=1 for 1 cycle; go to IDLE.
//   - No-conflict latency: valid asserts RD_LAT+2 cycles after the reg_rd_ena cycle.
// - Illegal sel_port (zero or multi-hot):
//   - Writes are dropped.
//   - Reads respond at T+1 with ERR_PATTERN ({DATA_W/16{16'hDEAD}}), valid=1, and do not leave IDLE.
//   - err_cnt increments in both cases.
// - reg_rd_ena while reg_busy: request ignored, err_cnt increments, outstanding read unaffected.
// - Illegal read and illegal write in the same cycle: err_cnt increments by 2.
// - err_cnt saturates at 16'hFFFF.
// - reg_rd_data holds its last value between valid pulses.
// CONFIGURATION
// - SONIC_REG_RD_PIPE_EN defined:
//   - An extra output register stage follows RESP.
//   - All read responses, ERR_PATTERN included, arrive 1 cycle later; reg_busy also stays high 1 cycle longer.
// - SONIC_REG_RD_PIPE_EN undefined: latencies exactly as stated in BEHAVIOUR.
// STRUCTURE
// - sonic_reg_pkg holds: rd_state_e enum (IDLE/ISSUE/WAIT/RESP), ERR_PATTERN constant, ERR_CNT_W=16, tgt_idx() decode function.
// - Sub-module sonic_reg_port_drv: per-port prg_addr/prg_wrdata/prg_wrena registers and write-over-read priority.
//   - Instantiated NUM_PORTS times in a generate loop.
// - Top level: sel decode and legality check, read FSM, response mux, err_cnt.
// TESTING
// - Write: sel=2'b10, addr 0x84, data 0x12345678 -> at T+1, prg_wrena bit 6 pulses 1 cycle; prg_addr port1=0x84; prg_wrdata port1=0x12345678.
// - Read: sel=2'b01, addr 0x40, prg_rddata port0/tgt1=0xCAFEF00D, RD_LAT=2 -> at T+4 valid=1, data=0xCAFEF00D; reg_busy high T+1..T+4.
// - Illegal read: sel=2'b11 -> at T+1 valid=1, data=0xDEADDEAD, err_cnt=1; FSM stays IDLE.
// - Conflict: write addr 0x00 and read addr 0x80, both port0, same cycle T -> prg_wrena bit 0 pulses at T+1; read valid at T+5.
// - Busy and reset:
//   - Second reg_rd_ena at T+2 -> ignored, err_cnt=1, single valid at T+4.
//   - rstn low during WAIT -> all outputs 0, no valid pulse after release.
// - Pipe option: rerun the read and illegal-read tests with SONIC_REG_RD_PIPE_EN -> valid at T+5 and T+2.

Source files
------------

// File: rtl/sonic_reg_router_pkg.sv
// Shared types and helpers for the sonic register router: read FSM states, error pattern, target decode.
// Pure declarations; no latency, no backpressure.
package sonic_reg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } rd_state_e;

    localparam int          ERR_CNT_W        = 16;
    localparam logic [15:0] ERR_PATTERN_WORD = 16'hDEAD;

    // Target index is the top tgt_w bits of the register address.
    function automatic int tgt_idx(input logic [31:0] addr, input int addr_w, input int tgt_w);
        logic [31:0] sh;
        logic [31:0] mask;
        sh   = addr >> (addr_w - tgt_w);
        mask = (32'd1 << tgt_w) - 32'd1;
        return int'(sh & mask);
    endfunction

endpackage

// File: rtl/sonic_reg_router_if.sv
// Downstream register-access bus plus the flattened per-port bank signals of the router.
// slave = router side, master = downstream/bank side.
interface sonic_reg_router_if #(
    parameter int NUM_PORTS = 2,
    parameter int NUM_TGT   = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32
);
    logic [NUM_PORTS-1:0]                sel_port;
    logic                                reg_wr_ena;
    logic [ADDR_W-1:0]                   reg_wr_addr;
    logic [DATA_W-1:0]                   reg_wr_data;
    logic                                reg_rd_ena;
    logic [ADDR_W-1:0]                   reg_rd_addr;
    logic [DATA_W-1:0]                   reg_rd_data;
    logic                                reg_rd_data_valid;
    logic                                reg_busy;
    logic [NUM_PORTS*ADDR_W-1:0]         prg_addr;
    logic [NUM_PORTS*DATA_W-1:0]         prg_wrdata;
    logic [NUM_PORTS*NUM_TGT-1:0]        prg_wrena;
    logic [NUM_PORTS*NUM_TGT*DATA_W-1:0] prg_rddata;

    modport slave (
        input  sel_port, reg_wr_ena, reg_wr_addr, reg_wr_data,
        input  reg_rd_ena, reg_rd_addr, prg_rddata,
        output reg_rd_data, reg_rd_data_valid, reg_busy,
        output prg_addr, prg_wrdata, prg_wrena
    );

    modport master (
        output sel_port, reg_wr_ena, reg_wr_addr, reg_wr_data,
        output reg_rd_ena, reg_rd_addr, prg_rddata,
        input  reg_rd_data, reg_rd_data_valid, reg_busy,
        input  prg_addr, prg_wrdata, prg_wrena
    );

endinterface

// File: rtl/sonic_reg_router_port_drv.sv
// One bank port: registered prg_addr/prg_wrdata and a 1-cycle prg_wrena pulse, write wins over read address load.
// Latency 1 cycle from request to bank-side outputs; never stalls.
module sonic_reg_port_drv #(
    parameter int NUM_TGT = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TGT_W   = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               wr_vld_i,
    input  logic [ADDR_W-1:0]  wr_addr_i,
    input  logic [DATA_W-1:0]  wr_dat_i,
    input  logic [TGT_W-1:0]   wr_tgt_i,
    input  logic               rd_ld_i,
    input  logic [ADDR_W-1:0]  rd_addr_i,
    output logic [ADDR_W-1:0]  prg_addr_o,
    output logic [DATA_W-1:0]  prg_wrdata_o,
    output logic [NUM_TGT-1:0] prg_wrena_o
);

    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic [DATA_W-1:0]  dat_q,   dat_d;
    logic [NUM_TGT-1:0] wrena_q, wrena_d;

    always_comb begin
        addr_d  = addr_q;
        dat_d   = dat_q;
        wrena_d = '0;
        if (wr_vld_i) begin
            addr_d            = wr_addr_i;
            dat_d             = wr_dat_i;
            wrena_d[wr_tgt_i] = 1'b1;
        end else if (rd_ld_i) begin
            addr_d = rd_addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            dat_q   <= '0;
            wrena_q <= '0;
        end else begin
            addr_q  <= addr_d;
            dat_q   <= dat_d;
            wrena_q <= wrena_d;
        end
    end

    assign prg_addr_o   = addr_q;
    assign prg_wrdata_o = dat_q;
    assign prg_wrena_o  = wrena_q;

endmodule

// File: rtl/sonic_reg_router.sv
// N-port BAR register router: sel decode, read FSM (IDLE/ISSUE/WAIT/RESP), response mux, saturating err_cnt.
// Read latency RD_LAT+2 (+1 with SONIC_REG_RD_PIPE_EN); reads while busy are dropped and counted as errors.
module sonic_reg_router
    import sonic_reg_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int NUM_TGT   = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 2
) (
    input  logic                 clk_in,
    input  logic                 rstn,
    sonic_reg_router_if.slave    bus,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int                TGT_W       = $clog2(NUM_TGT);
    localparam int                PORT_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [DATA_W-1:0] ERR_PATTERN = {(DATA_W/16){ERR_PATTERN_WORD}};
    localparam logic [3:0]        CNT_INIT    = 4'(RD_LAT - 1);

    rd_state_e            state_q;
    logic [PORT_W-1:0]    port_q;
    logic [TGT_W-1:0]     tgt_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [3:0]           cnt_q;
    logic                 hold_q;
    logic                 err_rsp_q;
    logic [DATA_W-1:0]    rd_data_q;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [PORT_W-1:0]    sel_idx;
    logic [TGT_W-1:0]     wr_tgt;
    logic [TGT_W-1:0]     rd_tgt;
    logic                 sel_legal;
    logic                 busy;
    logic                 wr_acc, wr_err;
    logic                 rd_acc, rd_err, rd_err_rsp;
    logic                 wr_hits_rd, rd_ld;
    logic [1:0]           err_inc;
    logic [ERR_CNT_W:0]   err_sum;
    logic [DATA_W-1:0]    bank_dat, resp_dat;
    logic                 resp_vld;

    logic [NUM_PORTS*ADDR_W-1:0]  prg_addr_w;
    logic [NUM_PORTS*DATA_W-1:0]  prg_wrdata_w;
    logic [NUM_PORTS*NUM_TGT-1:0] prg_wrena_w;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (bus.sel_port[i]) sel_idx = PORT_W'(i);
        end
    end

    assign sel_legal = $onehot(bus.sel_port);
    assign wr_tgt    = TGT_W'(tgt_idx(32'(bus.reg_wr_addr), ADDR_W, TGT_W));
    assign rd_tgt    = TGT_W'(tgt_idx(32'(bus.reg_rd_addr), ADDR_W, TGT_W));

`ifdef SONIC_REG_RD_PIPE_EN
    logic              pipe_vld_q;
    logic              pipe_busy_q;
    logic [DATA_W-1:0] pipe_dat_q;
    assign busy = (state_q != IDLE) | pipe_busy_q;
`else
    assign busy = (state_q != IDLE);
`endif

    assign wr_acc     = bus.reg_wr_ena & sel_legal;
    assign wr_err     = bus.reg_wr_ena & ~sel_legal;
    assign rd_acc     = bus.reg_rd_ena & sel_legal & ~busy;
    assign rd_err_rsp = bus.reg_rd_ena & ~sel_legal & ~busy;
    assign rd_err     = bus.reg_rd_ena & (busy | ~sel_legal);

    // A write to the port being read owns that port's prg_addr for the cycle.
    assign wr_hits_rd = wr_acc & (sel_idx == port_q);
    assign rd_ld      = (state_q == ISSUE) & ~hold_q & ~wr_hits_rd;

    assign err_inc   = {1'b0, wr_err} + {1'b0, rd_err};
    assign err_sum   = {1'b0, err_cnt_q} + (ERR_CNT_W+1)'(err_inc);
    assign err_cnt_d = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];

    assign bank_dat = bus.prg_rddata[(int'(port_q) * NUM_TGT + int'(tgt_q)) * DATA_W +: DATA_W];

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            port_q    <= '0;
            tgt_q     <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            hold_q    <= 1'b0;
            err_rsp_q <= 1'b0;
            rd_data_q <= '0;
            err_cnt_q <= '0;
        end else begin
            err_rsp_q <= 1'b0;
            err_cnt_q <= err_cnt_d;
            case (state_q)
                IDLE: begin
                    if (rd_acc) begin
                        port_q  <= sel_idx;
                        tgt_q   <= rd_tgt;
                        addr_q  <= bus.reg_rd_addr;
                        hold_q  <= wr_acc;
                        state_q <= ISSUE;
                    end else if (rd_err_rsp) begin
                        rd_data_q <= ERR_PATTERN;
                        err_rsp_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (hold_q || wr_hits_rd) begin
                        hold_q <= 1'b0;
                    end else begin
                        cnt_q   <= CNT_INIT;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) state_q <= RESP;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                RESP: begin
                    rd_data_q <= bank_dat;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Bank data is only guaranteed during RESP, so it is passed through then and held afterwards.
    assign resp_vld = (state_q == RESP) | err_rsp_q;
    assign resp_dat = (state_q == RESP) ? bank_dat : rd_data_q;

`ifdef SONIC_REG_RD_PIPE_EN
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            pipe_vld_q  <= 1'b0;
            pipe_busy_q <= 1'b0;
            pipe_dat_q  <= '0;
        end else begin
            pipe_vld_q  <= resp_vld;
            pipe_busy_q <= (state_q == RESP);
            if (resp_vld) pipe_dat_q <= resp_dat;
        end
    end
    assign bus.reg_rd_data       = pipe_dat_q;
    assign bus.reg_rd_data_valid = pipe_vld_q;
`else
    assign bus.reg_rd_data       = resp_dat;
    assign bus.reg_rd_data_valid = resp_vld;
`endif

    assign bus.reg_busy = busy;
    assign err_cnt      = err_cnt_q;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        sonic_reg_port_drv #(
            .NUM_TGT (NUM_TGT),
            .ADDR_W  (ADDR_W),
            .DATA_W  (DATA_W),
            .TGT_W   (TGT_W)
        ) u_drv (
            .clk_i        (clk_in),
            .rst_ni       (rstn),
            .wr_vld_i     (wr_acc & bus.sel_port[g]),
            .wr_addr_i    (bus.reg_wr_addr),
            .wr_dat_i     (bus.reg_wr_data),
            .wr_tgt_i     (wr_tgt),
            .rd_ld_i      (rd_ld & (port_q == PORT_W'(g))),
            .rd_addr_i    (addr_q),
            .prg_addr_o   (prg_addr_w[g*ADDR_W +: ADDR_W]),
            .prg_wrdata_o (prg_wrdata_w[g*DATA_W +: DATA_W]),
            .prg_wrena_o  (prg_wrena_w[g*NUM_TGT +: NUM_TGT])
        );
    end

    assign bus.prg_addr   = prg_addr_w;
    assign bus.prg_wrdata = prg_wrdata_w;
    assign bus.prg_wrena  = prg_wrena_w;

endmodule

// File: tb/tb_sonic_reg_router.sv
// Bench for sonic_reg_router: directed cases then random transactions against a reference model.
// Latencies shift by one when SONIC_REG_RD_PIPE_EN is defined.
module tb_sonic_reg_router;

    localparam int NP  = 2;
    localparam int NT  = 4;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int RL  = 2;
    localparam int WIN = 12;
`ifdef SONIC_REG_RD_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic        clk_in = 1'b0;
    logic        rstn   = 1'b0;
    logic [15:0] err_cnt;
    int          checks   = 0;
    int          failures = 0;
    int          exp_err  = 0;
    logic [NP*NT*DW-1:0] bank_v;

    always #5 clk_in = ~clk_in;

    sonic_reg_router_if #(.NUM_PORTS(NP), .NUM_TGT(NT), .ADDR_W(AW), .DATA_W(DW)) intf ();

    sonic_reg_router #(.NUM_PORTS(NP), .NUM_TGT(NT), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
        .clk_in  (clk_in),
        .rstn    (rstn),
        .bus     (intf.slave),
        .err_cnt (err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        intf.sel_port    = '0;
        intf.reg_wr_ena  = 1'b0;
        intf.reg_wr_addr = '0;
        intf.reg_wr_data = '0;
        intf.reg_rd_ena  = 1'b0;
        intf.reg_rd_addr = '0;
    endtask

    // Address space is split into NT equal target regions.
    function automatic int tgt_of(input logic [7:0] a);
        return int'(a) / ((1 << AW) / NT);
    endfunction

    function automatic bit legal(input logic [1:0] s);
        return (s == 2'b01) || (s == 2'b10);
    endfunction

    function automatic int port_of(input logic [1:0] s);
        return (s == 2'b10) ? 1 : 0;
    endfunction

    function automatic logic [31:0] bank_word(input int p, input int t);
        return bank_v[(p*NT + t)*DW +: DW];
    endfunction

    task automatic randomize_bank();
        for (int i = 0; i < NP*NT; i++) bank_v[i*DW +: DW] = $urandom;
        intf.prg_rddata = bank_v;
    endtask

    task automatic run_txn(input string tag, input logic [1:0] sel, input bit wr, input bit rd,
                           input logic [7:0] wa, input logic [31:0] wd, input logic [7:0] ra);
        bit          lg;
        int          p;
        int          exp_lat;
        int          first_v;
        int          nval;
        int          nbusy;
        logic [31:0] exp_dat;
        logic [7:0]  exp_wrena;
        logic [31:0] got_dat;
        logic [7:0]  got_wrena1;
        logic        late_wrena;
        logic [7:0]  got_paddr_w;
        logic [7:0]  got_paddr_r;
        logic [31:0] got_wdat;
        lg = legal(sel);
        p  = port_of(sel);
        first_v = -1; nval = 0; nbusy = 0;
        got_dat = '0; got_wrena1 = '0; late_wrena = 1'b0;
        got_paddr_w = '0; got_paddr_r = '0; got_wdat = '0;

        if (wr && !lg) exp_err++;
        if (rd && !lg) exp_err++;
        if (exp_err > 65535) exp_err = 65535;
        exp_wrena = (wr && lg) ? 8'(1 << (p*NT + tgt_of(wa))) : 8'h00;
        exp_lat   = lg ? (RL + 2 + (wr ? 1 : 0) + PIPE) : (1 + PIPE);
        exp_dat   = lg ? bank_word(p, tgt_of(ra)) : 32'hDEADDEAD;

        intf.sel_port    = sel;
        intf.reg_wr_ena  = wr;
        intf.reg_wr_addr = wa;
        intf.reg_wr_data = wd;
        intf.reg_rd_ena  = rd;
        intf.reg_rd_addr = ra;
        for (int c = 1; c <= WIN; c++) begin
            tick();
            if (c == 1) begin
                idle_inputs();
                got_wrena1  = intf.prg_wrena;
                got_paddr_w = intf.prg_addr[p*AW +: AW];
                got_wdat    = intf.prg_wrdata[p*DW +: DW];
            end else if (intf.prg_wrena != '0) begin
                late_wrena = 1'b1;
            end
            if (intf.reg_busy) nbusy++;
            if (intf.reg_rd_data_valid) begin
                nval++;
                if (first_v < 0) begin
                    first_v     = c;
                    got_dat     = intf.reg_rd_data;
                    got_paddr_r = intf.prg_addr[p*AW +: AW];
                end
            end
        end

        chk({tag, ".wrena"}, 64'(got_wrena1), 64'(exp_wrena));
        chk({tag, ".wrena_len"}, 64'(late_wrena), 64'(0));
        if (wr && lg) begin
            chk({tag, ".wr_addr"}, 64'(got_paddr_w), 64'(wa));
            chk({tag, ".wr_data"}, 64'(got_wdat), 64'(wd));
        end
        chk({tag, ".nvalid"}, 64'(nval), 64'(rd ? 1 : 0));
        if (rd) begin
            chk({tag, ".latency"}, 64'(first_v), 64'(exp_lat));
            chk({tag, ".rd_data"}, 64'(got_dat), 64'(exp_dat));
        end
        if (rd && lg) chk({tag, ".rd_addr"}, 64'(got_paddr_r), 64'(ra));
        chk({tag, ".busy_cycles"}, 64'(nbusy), 64'((rd && lg) ? exp_lat : 0));
        chk({tag, ".err_cnt"}, 64'(err_cnt), 64'(exp_err));
    endtask

    initial begin
        int          first_v;
        int          nval;
        int          nbusy;
        int          n_sat;
        logic [31:0] got_dat;
        logic [1:0]  sel;
        int          r;
        int          op;

        idle_inputs();
        bank_v = '0;
        intf.prg_rddata = bank_v;

        // Reset state
        rstn = 1'b0;
        tick();
        tick();
        chk("rst.valid",   64'(intf.reg_rd_data_valid), 64'(0));
        chk("rst.busy",    64'(intf.reg_busy),          64'(0));
        chk("rst.err_cnt", 64'(err_cnt),                64'(0));
        chk("rst.wrena",   64'(intf.prg_wrena),         64'(0));
        chk("rst.addr",    64'(intf.prg_addr),          64'(0));
        chk("rst.rd_data", 64'(intf.reg_rd_data),       64'(0));
        rstn = 1'b1;
        tick();

        // Directed cases
        run_txn("wr", 2'b10, 1'b1, 1'b0, 8'h84, 32'h12345678, 8'h00);
        randomize_bank();
        bank_v[(0*NT + 1)*DW +: DW] = 32'hCAFEF00D;
        intf.prg_rddata = bank_v;
        run_txn("rd",       2'b01, 1'b0, 1'b1, 8'h00, 32'h0, 8'h40);
        run_txn("ill_rd11", 2'b11, 1'b0, 1'b1, 8'h00, 32'h0, 8'h40);
        run_txn("ill_rd00", 2'b00, 1'b0, 1'b1, 8'h00, 32'h0, 8'hC4);
        run_txn("ill_wr",   2'b00, 1'b1, 1'b0, 8'h10, 32'h55AA55AA, 8'h00);
        run_txn("ill_both", 2'b11, 1'b1, 1'b1, 8'h20, 32'h1, 8'h20);
        run_txn("conflict", 2'b01, 1'b1, 1'b1, 8'h00, 32'hA5A5F00F, 8'h80);

        // Second read while busy: ignored, counted, original read completes once
        first_v = -1; nval = 0; got_dat = '0;
        intf.sel_port = 2'b01; intf.reg_rd_ena = 1'b1; intf.reg_rd_addr = 8'h40;
        exp_err++;
        for (int c = 1; c <= WIN; c++) begin
            tick();
            idle_inputs();
            if (c == 2) begin
                intf.sel_port = 2'b01; intf.reg_rd_ena = 1'b1; intf.reg_rd_addr = 8'hC0;
            end
            if (intf.reg_rd_data_valid) begin
                nval++;
                if (first_v < 0) begin
                    first_v = c;
                    got_dat = intf.reg_rd_data;
                end
            end
        end
        chk("busy.nvalid",  64'(nval),    64'(1));
        chk("busy.latency", 64'(first_v), 64'(RL + 2 + PIPE));
        chk("busy.rd_data", 64'(got_dat), 64'(bank_word(0, 1)));
        chk("busy.err_cnt", 64'(err_cnt), 64'(exp_err));

        // Reset while the read is waiting on the bank
        intf.sel_port = 2'b10; intf.reg_rd_ena = 1'b1; intf.reg_rd_addr = 8'h40;
        tick();
        idle_inputs();
        tick();
        rstn = 1'b0;
        #1;
        exp_err = 0;
        chk("rstw.valid",   64'(intf.reg_rd_data_valid), 64'(0));
        chk("rstw.busy",    64'(intf.reg_busy),          64'(0));
        chk("rstw.err_cnt", 64'(err_cnt),                64'(exp_err));
        chk("rstw.rd_data", 64'(intf.reg_rd_data),       64'(0));
        chk("rstw.addr",    64'(intf.prg_addr),          64'(0));
        tick();
        rstn = 1'b1;
        nval = 0; nbusy = 0;
        for (int c = 1; c <= WIN; c++) begin
            tick();
            if (intf.reg_rd_data_valid) nval++;
            if (intf.reg_busy) nbusy++;
        end
        chk("rstw.nvalid", 64'(nval),  64'(0));
        chk("rstw.nbusy",  64'(nbusy), 64'(0));

        // Random transactions
        for (int i = 0; i < 40; i++) begin
            randomize_bank();
            r  = $urandom_range(0, 7);
            sel = (r < 3) ? 2'b01 : (r < 6) ? 2'b10 : (r == 6) ? 2'b00 : 2'b11;
            op = $urandom_range(1, 3);
            run_txn($sformatf("rnd%0d", i), sel, op[0], op[1],
                    8'($urandom), $urandom, 8'($urandom));
        end

        // Saturation: illegal read and write every cycle
        n_sat = 32800;
        intf.sel_port = 2'b00; intf.reg_wr_ena = 1'b1; intf.reg_rd_ena = 1'b1;
        for (int c = 0; c < n_sat; c++) tick();
        idle_inputs();
        exp_err = exp_err + 2*n_sat;
        if (exp_err > 65535) exp_err = 65535;
        chk("sat.err_cnt", 64'(err_cnt), 64'(exp_err));
        tick();
        chk("sat.hold", 64'(err_cnt), 64'(exp_err));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
